// File: rtl/cpu_rf_pkg.sv
// Shared constants and types for the CPU register bank family.
package cpu_rf_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef logic [DATA_W_DEF-1:0] rf_data_t;
   typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bus of the register file: addresses, write ports, reserve, read results.
interface reg_file_sb_if import cpu_rf_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] Rd_Addr;
   logic [ADDR_W-1:0] Rs_Addr;
   logic [ADDR_W-1:0] Rm_Addr;
   logic              Rd_Wen;
   logic              Rs_Wen;
   logic [DATA_W-1:0] Rd_Data;
   logic [DATA_W-1:0] Rs_Data;
   logic              Rsv_Wen;
   logic [ADDR_W-1:0] Rsv_Addr;
   logic [DATA_W-1:0] Rd_Out;
   logic [DATA_W-1:0] Rs_Out;
   logic [DATA_W-1:0] Rm_Out;
   logic              Rd_Pend;
   logic              Rs_Pend;
   logic              Rm_Pend;
   logic              Collision;

   modport master (
      output Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data, Rsv_Wen, Rsv_Addr,
      input  Rd_Out, Rs_Out, Rm_Out, Rd_Pend, Rs_Pend, Rm_Pend, Collision
   );

   modport slave (
      input  Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data, Rsv_Wen, Rsv_Addr,
      output Rd_Out, Rs_Out, Rm_Out, Rd_Pend, Rs_Pend, Rm_Pend, Collision
   );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: stored data and pending bit, with optional write-through.
module rf_read_port #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int BYPASS = 0
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [DATA_W-1:0]      mem [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]   pend,
   input  logic                   rd_wen,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic [DATA_W-1:0]      rd_data,
   input  logic                   rs_wen,
   input  logic [ADDR_W-1:0]      rs_addr,
   input  logic [DATA_W-1:0]      rs_data,
   input  logic                   rsv_wen,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic [DATA_W-1:0]      data,
   output logic                   pend_out
);
   logic byp_en;
   logic rd_hit;
   logic rs_hit;
   logic rsv_hit;

   assign byp_en  = (BYPASS != 0);
   assign rd_hit  = rd_wen  && (rd_addr  == addr);
   assign rs_hit  = rs_wen  && (rs_addr  == addr);
   assign rsv_hit = rsv_wen && (rsv_addr == addr);

   // Rs has priority on bypass to mirror which write lands in storage.
   always_comb begin
      data     = mem[addr];
      pend_out = pend[addr];
      if (byp_en) begin
         if (rs_hit) begin
            data = rs_data;
         end else if (rd_hit) begin
            data = rd_data;
         end
         if (rs_hit || rd_hit) begin
            pend_out = rsv_hit;
         end
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with async clear, pending-result scoreboard and write-collision flag.
module reg_file_sb import cpu_rf_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 0
) (
   input logic          Clock,
   input logic          nReset,
   reg_file_sb_if.slave rf
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;
   logic              rd_we;
   logic              rs_we;
   logic              rsv_we;
   logic              collision_q;
   logic              zero_en;

   // R0 is masked at the enables, so storage, scoreboard and bypass never see it touched.
   assign zero_en = (ZERO_R0 != 0);
   assign rd_we   = rf.Rd_Wen  && !(zero_en && (rf.Rd_Addr  == '0));
   assign rs_we   = rf.Rs_Wen  && !(zero_en && (rf.Rs_Addr  == '0));
   assign rsv_we  = rf.Rsv_Wen && !(zero_en && (rf.Rsv_Addr == '0));

   always_comb begin
      pend_nxt = pend;
      if (rd_we)  pend_nxt[rf.Rd_Addr]  = 1'b0;
      if (rs_we)  pend_nxt[rf.Rs_Addr]  = 1'b0;
      if (rsv_we) pend_nxt[rf.Rsv_Addr] = 1'b1;
   end

   // Rs write is issued last so it wins a same-address collision.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         pend        <= '0;
         collision_q <= 1'b0;
      end else begin
         if (rd_we) mem[rf.Rd_Addr] <= rf.Rd_Data;
         if (rs_we) mem[rf.Rs_Addr] <= rf.Rs_Data;
         pend        <= pend_nxt;
         collision_q <= rf.Rd_Wen && rf.Rs_Wen && (rf.Rd_Addr == rf.Rs_Addr);
      end
   end

   assign rf.Collision = collision_q;

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_port (
      .addr(rf.Rd_Addr), .mem(mem), .pend(pend),
      .rd_wen(rd_we), .rd_addr(rf.Rd_Addr), .rd_data(rf.Rd_Data),
      .rs_wen(rs_we), .rs_addr(rf.Rs_Addr), .rs_data(rf.Rs_Data),
      .rsv_wen(rsv_we), .rsv_addr(rf.Rsv_Addr),
      .data(rf.Rd_Out), .pend_out(rf.Rd_Pend)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs_port (
      .addr(rf.Rs_Addr), .mem(mem), .pend(pend),
      .rd_wen(rd_we), .rd_addr(rf.Rd_Addr), .rd_data(rf.Rd_Data),
      .rs_wen(rs_we), .rs_addr(rf.Rs_Addr), .rs_data(rf.Rs_Data),
      .rsv_wen(rsv_we), .rsv_addr(rf.Rsv_Addr),
      .data(rf.Rs_Out), .pend_out(rf.Rs_Pend)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rm_port (
      .addr(rf.Rm_Addr), .mem(mem), .pend(pend),
      .rd_wen(rd_we), .rd_addr(rf.Rd_Addr), .rd_data(rf.Rd_Data),
      .rs_wen(rs_we), .rs_addr(rf.Rs_Addr), .rs_data(rf.Rs_Data),
      .rsv_wen(rsv_we), .rsv_addr(rf.Rsv_Addr),
      .data(rf.Rm_Out), .pend_out(rf.Rm_Pend)
   );
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: plain, bypass+zero-R0, and 32x32 instances side by side.
module tb_reg_file_sb;
   logic Clock;
   logic nReset;

   // ia: defaults; ib: BYPASS=1, ZERO_R0=1; ic: DATA_W=32, ADDR_W=5
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) ia ();
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) ib ();
   reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ic ();

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) ua (
      .Clock(Clock), .nReset(nReset), .rf(ia.slave));
   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) ub (
      .Clock(Clock), .nReset(nReset), .rf(ib.slave));
   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(0)) uc (
      .Clock(Clock), .nReset(nReset), .rf(ic.slave));

   localparam int A = 0, B = 10, C = 20;
   localparam int RD_OUT = 0, RS_OUT = 1, RM_OUT = 2, RD_P = 3, RS_P = 4, RM_P = 5, COLL = 6;

   typedef struct {
      int          sig;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   logic [31:0] act;
   int          n_vec = 0;
   int          n_bad = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [31:0] actual(int sig);
      case (sig)
         A+RD_OUT: return 32'(ia.Rd_Out);
         A+RS_OUT: return 32'(ia.Rs_Out);
         A+RM_OUT: return 32'(ia.Rm_Out);
         A+RD_P:   return 32'(ia.Rd_Pend);
         A+RS_P:   return 32'(ia.Rs_Pend);
         A+RM_P:   return 32'(ia.Rm_Pend);
         A+COLL:   return 32'(ia.Collision);
         B+RD_OUT: return 32'(ib.Rd_Out);
         B+RS_OUT: return 32'(ib.Rs_Out);
         B+RM_OUT: return 32'(ib.Rm_Out);
         B+RD_P:   return 32'(ib.Rd_Pend);
         B+RS_P:   return 32'(ib.Rs_Pend);
         B+RM_P:   return 32'(ib.Rm_Pend);
         B+COLL:   return 32'(ib.Collision);
         C+RD_OUT: return ic.Rd_Out;
         C+RS_OUT: return ic.Rs_Out;
         C+RM_OUT: return ic.Rm_Out;
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   function automatic logic [31:0] sweep_val(int i);
      return 32'hDEAD_0000 ^ (32'(i) * 32'h0101_0305);
   endfunction

   task automatic push_exp(int sig, logic [31:0] v, string nm);
      sb_q.push_back('{sig, v, nm});
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      ia.Rd_Wen = 1'b0; ia.Rs_Wen = 1'b0; ia.Rsv_Wen = 1'b0;
      ib.Rd_Wen = 1'b0; ib.Rs_Wen = 1'b0; ib.Rsv_Wen = 1'b0;
      ic.Rd_Wen = 1'b0; ic.Rs_Wen = 1'b0; ic.Rsv_Wen = 1'b0;
   endtask

   // Monitor: every expectation queued during a half-cycle is checked at the falling edge.
   initial begin
      forever begin
         @(negedge Clock);
         while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = actual(e.sig);
            n_vec++;
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      nReset = 1'b0;
      ia.Rd_Addr = '0; ia.Rs_Addr = '0; ia.Rm_Addr = '0; ia.Rsv_Addr = '0;
      ia.Rd_Data = '0; ia.Rs_Data = '0;
      ib.Rd_Addr = '0; ib.Rs_Addr = '0; ib.Rm_Addr = '0; ib.Rsv_Addr = '0;
      ib.Rd_Data = '0; ib.Rs_Data = '0;
      ic.Rd_Addr = '0; ic.Rs_Addr = '0; ic.Rm_Addr = '0; ic.Rsv_Addr = '0;
      ic.Rd_Data = '0; ic.Rs_Data = '0;
      idle();
      push_exp(A+RD_OUT, 0, "rst_rd_out");
      push_exp(A+RM_P,   0, "rst_rm_pend");
      push_exp(A+COLL,   0, "rst_coll");
      push_exp(B+COLL,   0, "rst_coll_b");
      @(negedge Clock);
      #1 nReset = 1'b1;

      // async clear mid-cycle
      cyc(); idle();
      ia.Rd_Wen = 1'b1; ia.Rd_Addr = 4'd3; ia.Rd_Data = 16'h1234;
      ia.Rsv_Wen = 1'b1; ia.Rsv_Addr = 4'd3;
      cyc(); idle();
      push_exp(A+RD_OUT, 32'h1234, "r3_written");
      push_exp(A+RD_P,   1,        "r3_rsv_with_wr");
      cyc(); idle();
      #1 nReset = 1'b0;
      push_exp(A+RD_OUT, 0, "async_clr_data");
      push_exp(A+RD_P,   0, "async_clr_pend");
      @(negedge Clock);
      #1 nReset = 1'b1;

      // write-write collision
      cyc(); idle();
      ia.Rd_Wen = 1'b1; ia.Rd_Addr = 4'd5; ia.Rd_Data = 16'hAAAA;
      ia.Rs_Wen = 1'b1; ia.Rs_Addr = 4'd5; ia.Rs_Data = 16'h5555;
      push_exp(A+COLL, 0, "coll_before_edge");
      cyc(); idle();
      ia.Rm_Addr = 4'd5;
      push_exp(A+RM_OUT, 32'h5555, "coll_rs_wins");
      push_exp(A+COLL,   1,        "coll_set");
      push_exp(A+RM_P,   0,        "wr_nonpend_stays");
      cyc(); idle();
      push_exp(A+COLL,   0,        "coll_clear");

      // bypass vs no bypass
      cyc(); idle();
      ia.Rd_Wen = 1'b1; ia.Rd_Addr = 4'd7; ia.Rd_Data = 16'h1111;
      ib.Rd_Wen = 1'b1; ib.Rd_Addr = 4'd7; ib.Rd_Data = 16'h1111;
      cyc(); idle();
      ia.Rd_Wen = 1'b1; ia.Rd_Data = 16'hBEEF; ia.Rm_Addr = 4'd7;
      ib.Rd_Wen = 1'b1; ib.Rd_Data = 16'hBEEF; ib.Rm_Addr = 4'd7;
      push_exp(A+RM_OUT, 32'h1111, "nobyp_old_value");
      push_exp(B+RM_OUT, 32'hBEEF, "byp_rd_data");
      cyc(); idle();
      ib.Rd_Wen = 1'b1; ib.Rd_Addr = 4'd9; ib.Rd_Data = 16'h0909;
      ib.Rs_Wen = 1'b1; ib.Rs_Addr = 4'd9; ib.Rs_Data = 16'h9999;
      push_exp(A+RM_OUT, 32'hBEEF, "nobyp_after_edge");
      push_exp(B+RM_OUT, 32'hBEEF, "byp_after_edge");
      push_exp(B+RD_OUT, 32'h9999, "byp_rs_priority");
      cyc(); idle();
      push_exp(B+COLL,   1,        "byp_coll_set");
      push_exp(B+RD_OUT, 32'h9999, "byp_coll_rs_wins");

      // pending bit under bypass
      cyc(); idle();
      ia.Rsv_Wen = 1'b1; ia.Rsv_Addr = 4'd4;
      ib.Rsv_Wen = 1'b1; ib.Rsv_Addr = 4'd4;
      cyc(); idle();
      ia.Rs_Wen = 1'b1; ia.Rs_Addr = 4'd4; ia.Rs_Data = 16'h4444;
      ib.Rs_Wen = 1'b1; ib.Rs_Addr = 4'd4; ib.Rs_Data = 16'h4444;
      push_exp(A+RS_P,   1,        "nobyp_pend_held");
      push_exp(A+RS_OUT, 0,        "nobyp_rs_old");
      push_exp(B+RS_P,   0,        "byp_pend_cleared");
      push_exp(B+RS_OUT, 32'h4444, "byp_rs_data");
      cyc(); idle();
      ib.Rsv_Wen = 1'b1; ib.Rsv_Addr = 4'd6;
      ib.Rd_Wen = 1'b1; ib.Rd_Addr = 4'd6; ib.Rd_Data = 16'h6666;
      push_exp(A+RS_P,   0,        "wr_clears_pend_r4");
      push_exp(A+RS_OUT, 32'h4444, "r4_written");
      push_exp(B+RD_P,   1,        "byp_rsv_beats_wr");

      // scoreboard on R2
      cyc(); idle();
      ia.Rsv_Wen = 1'b1; ia.Rsv_Addr = 4'd2; ia.Rs_Addr = 4'd2;
      push_exp(A+RS_P, 0, "rsv_not_before_edge");
      cyc(); idle();
      ia.Rsv_Wen = 1'b1;
      push_exp(A+RS_P, 1, "rsv_set");
      cyc(); idle();
      ia.Rd_Wen = 1'b1; ia.Rd_Addr = 4'd2; ia.Rd_Data = 16'h0042;
      push_exp(A+RS_P, 1, "rsv_twice_pending");
      cyc(); idle();
      push_exp(A+RS_P,   0,        "wr_clears_pend");
      push_exp(A+RS_OUT, 32'h0042, "wr_data_r2");
      cyc(); idle();
      ia.Rsv_Wen = 1'b1; ia.Rsv_Addr = 4'd2;
      ia.Rs_Wen = 1'b1; ia.Rs_Addr = 4'd2; ia.Rs_Data = 16'h0077;
      cyc(); idle();
      push_exp(A+RS_P,   1,        "rsv_wins_over_wr");
      push_exp(A+RS_OUT, 32'h0077, "rsv_wr_data");

      // hardwired-zero R0
      cyc(); idle();
      ib.Rd_Wen = 1'b1; ib.Rd_Addr = 4'd0; ib.Rd_Data = 16'hFFFF;
      ib.Rsv_Wen = 1'b1; ib.Rsv_Addr = 4'd0; ib.Rm_Addr = 4'd0;
      push_exp(B+RM_OUT, 0, "r0_no_bypass");
      push_exp(B+RM_P,   0, "r0_pend_no_bypass");
      cyc(); idle();
      ib.Rd_Wen = 1'b1; ib.Rs_Wen = 1'b1; ib.Rs_Addr = 4'd0; ib.Rs_Data = 16'hFFFF;
      push_exp(B+RM_OUT, 0, "r0_write_dropped");
      push_exp(B+RM_P,   0, "r0_rsv_dropped");
      cyc(); idle();
      push_exp(B+COLL,   1, "r0_coll_set");
      push_exp(B+RD_OUT, 0, "r0_after_coll");
      cyc(); idle();
      push_exp(B+COLL,   0, "r0_coll_clear");

      // 32x32 sweep
      for (int i = 0; i < 16; i++) begin
         cyc(); idle();
         ic.Rd_Wen = 1'b1; ic.Rd_Addr = 5'(i);      ic.Rd_Data = sweep_val(i);
         ic.Rs_Wen = 1'b1; ic.Rs_Addr = 5'(i + 16); ic.Rs_Data = sweep_val(i + 16);
      end
      for (int i = 0; i < 32; i++) begin
         cyc(); idle();
         ic.Rd_Addr = 5'(i);
         ic.Rs_Addr = 5'((i + 11) % 32);
         ic.Rm_Addr = 5'((i + 22) % 32);
         push_exp(C+RD_OUT, sweep_val(i),            $sformatf("sweep_rd_r%0d", i));
         push_exp(C+RS_OUT, sweep_val((i + 11) % 32), $sformatf("sweep_rs_r%0d", (i + 11) % 32));
         push_exp(C+RM_OUT, sweep_val((i + 22) % 32), $sformatf("sweep_rm_r%0d", (i + 22) % 32));
      end

      cyc(); idle();
      @(negedge Clock);
      #1;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
